// File: rtl/prog_dumper.sv
// prog_dumper: reads program-memory words and streams them out a UART TX line, low byte first.
// Build with DUMP_CSUM_EN defined to append a two's-complement checksum frame.

module prog_dumper #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int AW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [15:0]   mem_data,
    output logic          tx,
    output logic          busy,
    output logic          done
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(DIV - 1);
    localparam logic [3:0]    STOP_BIT = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD_LO,
        S_SEND_LO,
        S_LOAD_HI,
        S_SEND_HI,
        S_NEXT,
        S_CSUM,
        S_SEND_CS,
        S_FIN
    } state_t;

`ifdef DUMP_CSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_FIN;
`endif

    state_t state;
    state_t state_nx;

    logic [AW-1:0] base_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] word_cnt;
    logic [AW-1:0] addr_q;
    logic [15:0]   word;

    logic [8:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] baud_cnt;
    logic          tx_act;

    logic          accept;
    logic          load;
    logic [7:0]    load_byte;
    logic          done_nx;
    logic          frame_end;
    logic          in_stop;
    logic          load_ok;
    logic          last_word;

`ifdef DUMP_CSUM_EN
    logic [7:0]    csum;
`endif

    // A new frame may start when the line is idle or exactly as the current stop bit ends.
    assign frame_end = tx_act && (bit_cnt == STOP_BIT) && (baud_cnt == BAUD_MAX);
    assign in_stop   = tx_act && (bit_cnt == STOP_BIT);
    assign load_ok   = !tx_act || frame_end;
    assign last_word = (word_cnt + AW'(1)) == len_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; send states leave at the stop bit so the next load lands gap-free
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start && !done) begin
                    state_nx = (len == '0) ? S_TAIL : S_FETCH;
                end
            end
            S_FETCH:   state_nx = S_WAIT;
            S_WAIT:    state_nx = S_LOAD_LO;
            S_LOAD_LO: if (load_ok) state_nx = S_SEND_LO;
            S_SEND_LO: if (in_stop) state_nx = S_LOAD_HI;
            S_LOAD_HI: if (load_ok) state_nx = S_SEND_HI;
            S_SEND_HI: if (in_stop) state_nx = S_NEXT;
            S_NEXT:    state_nx = last_word ? S_TAIL : S_FETCH;
`ifdef DUMP_CSUM_EN
            S_CSUM:    if (load_ok) state_nx = S_SEND_CS;
            S_SEND_CS: if (in_stop) state_nx = S_FIN;
`endif
            S_FIN:     if (!tx_act) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Output decode: memory strobe, frame load requests and completion
    always_comb begin
        mem_rd    = 1'b0;
        mem_addr  = addr_q;
        accept    = 1'b0;
        load      = 1'b0;
        load_byte = word[7:0];
        done_nx   = 1'b0;
        unique case (state)
            S_IDLE: accept = start && !done;
            S_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = base_q + word_cnt;
            end
            S_LOAD_LO: begin
                load      = load_ok;
                load_byte = word[7:0];
            end
            S_LOAD_HI: begin
                load      = load_ok;
                load_byte = word[15:8];
            end
`ifdef DUMP_CSUM_EN
            S_CSUM: begin
                load      = load_ok;
                load_byte = 8'd0 - csum;
            end
`endif
            S_FIN:   done_nx = !tx_act;
            default: ;
        endcase
    end

    // Job registers: latched request, word counter, held address, fetched word, status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q   <= '0;
            len_q    <= '0;
            word_cnt <= '0;
            addr_q   <= '0;
            word     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (accept) begin
                base_q   <= base;
                len_q    <= len;
                word_cnt <= '0;
                busy     <= 1'b1;
            end
            if (state == S_FETCH) begin
                addr_q <= mem_addr;
            end
            if (state == S_WAIT) begin
                word <= mem_data;
            end
            if (state == S_NEXT) begin
                word_cnt <= word_cnt + AW'(1);
            end
            done <= done_nx;
            if (done_nx) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef DUMP_CSUM_EN
    // Running mod-256 sum of every data byte handed to the transmitter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= 8'd0;
        end else if (accept) begin
            csum <= 8'd0;
        end else if (load && (state != S_CSUM)) begin
            csum <= csum + load_byte;
        end
    end
`endif

    // 8N1 transmitter; the baud counter restarts with every loaded frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx       <= 1'b1;
            shreg    <= '1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx_act   <= 1'b0;
        end else if (load) begin
            tx       <= 1'b0;
            shreg    <= {1'b1, load_byte};
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx_act   <= 1'b1;
        end else if (tx_act) begin
            if (baud_cnt == BAUD_MAX) begin
                baud_cnt <= '0;
                if (bit_cnt == STOP_BIT) begin
                    tx_act <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_dumper.sv
// tb_prog_dumper: directed bench for prog_dumper at DIV=10.
// Expected serial stream is built from memory contents; the tx line is compared every cycle.

module tb_prog_dumper;

    localparam int DIV   = 10;
    localparam int FRAME = 10 * DIV;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic [15:0] base     = 16'h0;
    logic [15:0] len      = 16'h0;
    logic [15:0] mem_data = 16'h0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        tx;
    logic        busy;
    logic        done;

    prog_dumper #(
        .CLK_FREQ(1000),
        .BAUD    (100),
        .AW      (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .base    (base),
        .len     (len),
        .mem_addr(mem_addr),
        .mem_rd  (mem_rd),
        .mem_data(mem_data),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Memory: explicit entries, otherwise data equals address
    logic [15:0] mem_tbl [logic [15:0]];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (mem_tbl.exists(a)) return mem_tbl[a];
        return a;
    endfunction

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_word(mem_addr);
    end

    int errors = 0;
    int checks = 0;

    bit mon_on   = 1'b0;
    bit started  = 1'b0;
    int pos      = 0;
    int done_cnt = 0;
    logic [7:0]  rx_sh = 8'h0;
    logic [7:0]  exp_bytes [$];
    logic [7:0]  rx_bytes  [$];
    logic [15:0] exp_addrs [$];
    logic [15:0] rd_log    [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Per-cycle comparison against the expected byte stream and read list
    task automatic sample();
        int total;
        int fpos;
        int bi;
        logic [7:0] eb;
        logic ebit;
        total = exp_bytes.size() * FRAME;
        if (mem_rd) begin
            rd_log.push_back(mem_addr);
            if (exp_addrs.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_rd_extra: got read of %h want none", mem_addr);
            end else begin
                check("mem_addr", 32'(mem_addr), 32'(exp_addrs.pop_front()));
            end
        end
        if (!started && tx === 1'b0) begin
            started = 1'b1;
            pos = 0;
        end
        if (started) begin
            if (pos < total) begin
                fpos = pos % FRAME;
                bi   = fpos / DIV;
                eb   = exp_bytes[pos / FRAME];
                if (bi == 0) ebit = 1'b0;
                else if (bi == 9) ebit = 1'b1;
                else ebit = eb[bi-1];
                check("tx_bit", 32'(tx), 32'(ebit));
                check("busy_during_tx", 32'(busy), 1);
                if (fpos % DIV == DIV / 2) begin
                    if (bi >= 1 && bi <= 8) rx_sh[bi-1] = tx;
                    if (bi == 9) rx_bytes.push_back(rx_sh);
                end
            end else begin
                check("tx_idle_after", 32'(tx), 1);
            end
            pos++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("done_after_frames", 32'(pos >= total), 1);
            check("busy_at_done", 32'(busy), 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_on) sample();
    endtask

    task automatic run_dump(input string name, input logic [15:0] b,
                            input logic [15:0] n, input bit inject,
                            output int lat);
        logic [7:0]  sum;
        logic [15:0] a;
        logic [15:0] w;
        bit got;
        int budget;
        sum = 8'h0;
        got = 1'b0;
        exp_bytes.delete();
        exp_addrs.delete();
        rx_bytes.delete();
        rd_log.delete();
        for (int i = 0; i < int'(n); i++) begin
            a = b + 16'(i);
            exp_addrs.push_back(a);
            w = mem_word(a);
            exp_bytes.push_back(w[7:0]);
            exp_bytes.push_back(w[15:8]);
            sum = sum + w[7:0] + w[15:8];
        end
`ifdef DUMP_CSUM_EN
        exp_bytes.push_back(8'd0 - sum);
`endif
        started  = 1'b0;
        pos      = 0;
        done_cnt = 0;
        mon_on   = 1'b1;
        tick();
        base  = b;
        len   = n;
        start = 1'b1;
        lat = 0;
        budget = (int'(n) * 2 + 2) * FRAME + 50;
        while (!got && lat < budget) begin
            tick();
            lat++;
            start = 1'b0;
            base  = ~b;
            len   = n + 16'd3;
            if (lat == 1) check({name, "_busy_early"}, 32'(busy), 1);
            if (inject && lat == 30) begin
                start = 1'b1;
                base  = 16'h1234;
                len   = 16'd7;
            end
            if (done === 1'b1) begin
                got = 1'b1;
                if (inject) start = 1'b1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done want done within %0d cycles", name, budget);
        end
        repeat (40) begin
            tick();
            start = 1'b0;
        end
        check({name, "_done_cnt"}, 32'(done_cnt), 1);
        check({name, "_reads_left"}, 32'(exp_addrs.size()), 0);
        check({name, "_busy_after"}, 32'(busy), 0);
        check({name, "_rx_count"}, 32'(rx_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
            check({name, "_rx_byte"}, 32'(rx_bytes[i]), 32'(exp_bytes[i]));
        end
        mon_on = 1'b0;
    endtask

    initial begin
        int lat;
        int cnt;
        logic [7:0]  wrap_bytes [6];
        logic [15:0] wrap_addrs [3];
        wrap_bytes = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        wrap_addrs = '{16'hFFFE, 16'hFFFF, 16'h0000};

        repeat (3) tick();
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        rst = 1'b1;
        repeat (2) tick();

        mem_tbl[16'h0010] = 16'hA55A;
        run_dump("single", 16'h0010, 16'd1, 1'b1, lat);
        check("single_rd_cnt", 32'(rd_log.size()), 1);
        if (rd_log.size() >= 1) check("single_rd_addr", 32'(rd_log[0]), 32'h0010);
        if (rx_bytes.size() >= 2) begin
            check("single_lo", 32'(rx_bytes[0]), 32'h5A);
            check("single_hi", 32'(rx_bytes[1]), 32'hA5);
        end

        run_dump("wrap", 16'hFFFE, 16'd3, 1'b0, lat);
        check("wrap_rd_cnt", 32'(rd_log.size()), 3);
        for (int i = 0; i < 3 && i < rd_log.size(); i++) begin
            check("wrap_rd_addr", 32'(rd_log[i]), 32'(wrap_addrs[i]));
        end
        for (int i = 0; i < 6 && i < rx_bytes.size(); i++) begin
            check("wrap_byte", 32'(rx_bytes[i]), 32'(wrap_bytes[i]));
        end

        run_dump("len0", 16'h0040, 16'd0, 1'b0, lat);
        check("len0_reads", 32'(rd_log.size()), 0);
`ifdef DUMP_CSUM_EN
        check("len0_frames", 32'(rx_bytes.size()), 1);
        if (rx_bytes.size() >= 1) check("len0_csum", 32'(rx_bytes[0]), 32'h00);
`else
        check("len0_frames", 32'(rx_bytes.size()), 0);
        check("len0_latency", 32'(lat), 2);
`endif

        mem_tbl[16'h0100] = 16'h0201;
        mem_tbl[16'h0101] = 16'h0403;
        run_dump("csum", 16'h0100, 16'd2, 1'b0, lat);
        if (rx_bytes.size() >= 4) begin
            check("csum_b0", 32'(rx_bytes[0]), 32'h01);
            check("csum_b1", 32'(rx_bytes[1]), 32'h02);
            check("csum_b2", 32'(rx_bytes[2]), 32'h03);
            check("csum_b3", 32'(rx_bytes[3]), 32'h04);
        end
`ifdef DUMP_CSUM_EN
        check("csum_count", 32'(rx_bytes.size()), 5);
        if (rx_bytes.size() >= 5) check("csum_b4", 32'(rx_bytes[4]), 32'hF6);
`else
        check("csum_count", 32'(rx_bytes.size()), 4);
`endif

        tick();
        base  = 16'h0010;
        len   = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (tx !== 1'b0 && cnt < 20) begin
            tick();
            cnt++;
        end
        check("mr_start_bit", 32'(tx), 0);
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        check("mr_tx", 32'(tx), 1);
        check("mr_busy", 32'(busy), 0);
        check("mr_mem_rd", 32'(mem_rd), 0);
        check("mr_done", 32'(done), 0);
        tick();
        rst = 1'b1;
        cnt = 0;
        repeat (300) begin
            tick();
            if (tx !== 1'b1) cnt++;
        end
        check("mr_no_resume", 32'(cnt), 0);
        check("mr_busy_after", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_dumper.md
Name: prog_dumper

Overview:
- Read-back counterpart to the UART program loader: reads 16-bit words from program memory and sends them out a UART TX line.
- Lets the host verify a downloaded image.
- Sits beside the loader on the raw board clock, ahead of the clock divider.
- Uses the program-memory read port while the core is held in reset.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 115200, UART bit rate. Bit period DIV = CLK_FREQ/BAUD cycles, integer-truncated (434 at defaults).
- AW, 16, program-memory word-address width.

Ports:
- clk  input  1  board clock; all logic on its rising edge.
- rst  input  1  asynchronous active-low reset; 0 = reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- base  input  AW  first word address; latched on accepted start.
- len  input  AW  number of words to send; latched on accepted start.
- mem_addr  output  AW  program-memory read address.
- mem_rd  output  1  read strobe. Memory returns data exactly 1 cycle later (registered altsyncram port).
- mem_data  input  16  read data.
- tx  output  1  UART serial out, 8N1, idle high.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset values: tx=1, busy=0, done=0, mem_rd=0, mem_addr=0, internal counters 0. State is IDLE.
- Asserting rst mid-operation aborts immediately. tx goes to 1 asynchronously and no partial byte is completed.
- FSM states: IDLE, FETCH, WAIT, LOAD_LO, SEND_LO, LOAD_HI, SEND_HI, NEXT, (CSUM, SEND_CS), FIN.
- IDLE:
  - On start=1, latch base and len, clear the word counter, set busy=1.
  - If len=0, go to FIN (or CSUM if enabled); otherwise go to FETCH.
  - start while busy is ignored.
- FETCH: mem_addr = base + word_cnt, modulo 2^AW (address wraps from all-ones to 0). mem_rd=1 for exactly one cycle. Go to WAIT.
- WAIT: mem_rd=0. Capture mem_data into a 16-bit word register at the end of this cycle.
- LOAD_LO / SEND_LO: transmit word[7:0].
- LOAD_HI / SEND_HI: transmit word[15:8]. Byte order is little-endian, low byte first.
- Byte transmission:
  - Frame is start bit 0, data bits LSB first, stop bit 1.
  - Each bit lasts exactly DIV clk cycles, so one frame is 10*DIV cycles.
  - The baud counter restarts at each frame start.
  - Back-to-back frames have no idle gap between one stop bit and the next start bit. The memory fetch of the next word overlaps the high byte's stop bit.
- NEXT: increment word_cnt. If word_cnt == len, go to FIN (or CSUM); else go to FETCH.
- FIN: done=1 for one cycle, busy=0, tx=1, return to IDLE.
- A start asserted in the same cycle as done is ignored. start is accepted from the following cycle.
- mem_rd is never asserted outside FETCH. mem_addr holds its last value otherwise.

Optional Feature:
- Macro: DUMP_CSUM_EN.
- Defined:
  - An 8-bit running sum of every transmitted data byte is kept, cleared on accepted start.
  - After the last word, CSUM computes the two's complement of the sum; SEND_CS transmits it as one more frame, then FIN.
  - The mod-256 sum of all bytes including the checksum is 0.
  - len=0 sends the single byte 0x00.
- Not defined: no checksum logic is built; NEXT/IDLE go directly to FIN.

Test Plan:
- Bench with CLK_FREQ=1000, BAUD=100 (DIV=10).
- Reset: rst=0 -> tx=1, busy=0, done=0, mem_rd=0. Drop rst mid-frame -> tx=1 within the same cycle.
- Single word: memory[0x0010]=0xA55A, base=0x0010, len=1, start pulse.
  - mem_rd high one cycle with mem_addr=0x0010.
  - tx sends 0x5A then 0xA5, each 100 cycles, no gap.
  - done pulses once. busy low afterwards.
- Multi-word wrap: base=0xFFFE, len=3, memory returns address as data.
  - Addresses read are 0xFFFE, 0xFFFF, 0x0000.
  - Bytes are FE FF FF FF 00 00.
- len=0 without macro -> no tx edge, done 2 cycles after start.
- len=0 with DUMP_CSUM_EN -> one frame 0x00, then done.
- start pulses during busy and in the done cycle -> ignored, exactly one dump of the original base/len.
- DUMP_CSUM_EN: words 0x0201, 0x0403 -> bytes 01 02 03 04, then checksum 0xF6.
